// File: rtl/qspi_rx_capture_ctrl_pkg.sv
// Shared types and helpers for the QSPI read-phase capture controller.
//   lane_mode_e : encoded data-line mode as presented on lane_mode
//   rx_state_e  : capture sequencer states
//   lane_bits   : bits captured per sample pulse for a lane mode
//   lane_onehot : {use_4, use_2, use_1} line select for the sampling register
package qspi_pkg;

   localparam int unsigned WORD_BITS = 32;
   localparam int unsigned WB_W      = 6;   // holds 0..WORD_BITS
   localparam int unsigned NBYTES_W  = 3;   // holds 1..4

   typedef enum logic [1:0] {
      LANE_1       = 2'b00,
      LANE_2       = 2'b01,
      LANE_4       = 2'b10,
      LANE_ILLEGAL = 2'b11
   } lane_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_PUSH,
      ST_FINISH
   } rx_state_e;

   function automatic logic [2:0] lane_bits(input lane_mode_e m);
      case (m)
         LANE_2:  return 3'd2;
         LANE_4:  return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [2:0] lane_onehot(input lane_mode_e m);
      case (m)
         LANE_1:  return 3'b001;
         LANE_2:  return 3'b010;
         LANE_4:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/qspi_rx_capture_ctrl_if.sv
// Push-side link between the capture controller and the AHB-side RX FIFO.
//   full   : FIFO cannot accept a word
//   push   : one-cycle push strobe
//   wdata  : pushed word, valid bytes in the LSBs
//   last   : pushed word is the final word of the transfer
//   nbytes : valid bytes in the pushed word, 1..4
interface qspi_rx_capture_ctrl_if;
   import qspi_pkg::*;

   logic                          full;
   logic                          push;
   logic [WORD_BITS-1:0]          wdata;
   logic                          last;
   logic [NBYTES_W-1:0]           nbytes;

   modport master (input full, output push, output wdata, output last, output nbytes);
   modport slave  (output full, input push, input wdata, input last, input nbytes);

endinterface

// File: rtl/qspi_rx_capture_ctrl.sv
// Read-phase capture sequencer for the QSPI controller. Gates sample pulses into
// the sampling shift register, counts bits per lane mode and pushes each full or
// final partial word into the RX FIFO, holding SCLK while a word is pending.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start, abort          : one-cycle control pulses
//   rx_byte_count         : bytes to read (latched on start)
//   lane_mode             : 00/01/10 = 1/2/4 lines, 11 illegal (latched on start)
//   sample_pulse          : strobe from the SCLK generator
//   sample_en             : gated strobe to the sampling register
//   use_N_io_lines_out    : one-hot latched mode to the sampling register
//   sample_data           : sampling register contents
//   fifo                  : RX FIFO push interface (master side)
//   sclk_hold             : stop the SCLK generator issuing sample pulses
//   busy, done            : activity flag and completion pulse
//   err_mode, err_overrun : sticky error flags, cleared by the next start
module qspi_rx_capture_ctrl
   import qspi_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CNT_W-1:0]          rx_byte_count,
   input  logic [1:0]                lane_mode,
   input  logic                      sample_pulse,
   output logic                      sample_en,
   output logic                      use_1_io_lines_out,
   output logic                      use_2_io_lines_out,
   output logic                      use_4_io_lines_out,
   input  logic [WORD_BITS-1:0]      sample_data,
   qspi_rx_capture_ctrl_if.master    fifo,
   output logic                      sclk_hold,
   output logic                      busy,
   output logic                      done,
   output logic                      err_mode,
   output logic                      err_overrun
);

   localparam int unsigned BL_W = CNT_W + 3;

   rx_state_e        state;
   lane_mode_e       lane_q;
   logic [BL_W-1:0]  bits_left;
   logic [BL_W-1:0]  bits_left_nxt;
   logic [WB_W-1:0]  word_bits;
   logic [WB_W-1:0]  word_bits_nxt;
   logic [2:0]       use_lines;
   logic             word_end_c;

   assign use_1_io_lines_out = use_lines[0];
   assign use_2_io_lines_out = use_lines[1];
   assign use_4_io_lines_out = use_lines[2];

   // Bit accounting for the current pulse and the Mealy hold/push decode.
   always_comb begin
      bits_left_nxt = bits_left - BL_W'(lane_bits(lane_q));
      word_bits_nxt = word_bits + WB_W'(lane_bits(lane_q));
      word_end_c    = (word_bits_nxt == WB_W'(WORD_BITS)) || (bits_left_nxt == '0);

      sample_en     = (state == ST_SAMPLE) && sample_pulse;
      // Hold in the completing-pulse cycle so no pulse lands before the push.
      sclk_hold     = (state == ST_PUSH) || (state == ST_FINISH) ||
                      (sample_en && word_end_c);
      busy          = (state != ST_IDLE);

      // Abort wins over a push in the same cycle.
      fifo.push     = (state == ST_PUSH) && !fifo.full && !abort;
      fifo.wdata    = (state == ST_PUSH) ? sample_data : '0;
      fifo.last     = (state == ST_PUSH) && (bits_left == '0);
      fifo.nbytes   = (state == ST_PUSH) ? word_bits[WB_W-1:3] : '0;
   end

   // Sequencer with registered done, mode and error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         lane_q      <= LANE_1;
         bits_left   <= '0;
         word_bits   <= '0;
         use_lines   <= '0;
         done        <= 1'b0;
         err_mode    <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         done <= 1'b0;

         // A pulse arriving while SCLK is held was never meant to happen.
         if (sample_pulse && (state != ST_SAMPLE) && sclk_hold) begin
            err_overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  lane_q      <= lane_mode_e'(lane_mode);
                  err_mode    <= 1'b0;
                  err_overrun <= 1'b0;
                  word_bits   <= '0;
                  bits_left   <= {rx_byte_count, 3'b000};
                  if (rx_byte_count == '0) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else if (lane_mode_e'(lane_mode) == LANE_ILLEGAL) begin
                     err_mode <= 1'b1;
                     state    <= ST_FINISH;
                     done     <= 1'b1;
                  end else begin
                     use_lines <= lane_onehot(lane_mode_e'(lane_mode));
                     state     <= ST_SAMPLE;
                  end
               end
            end

            ST_SAMPLE: begin
               if (abort) begin
                  state <= ST_FINISH;
                  done  <= 1'b1;
               end else if (sample_pulse) begin
                  word_bits <= word_bits_nxt;
                  bits_left <= bits_left_nxt;
                  if (word_end_c) begin
                     state <= ST_PUSH;
                  end
               end
            end

            ST_PUSH: begin
               if (abort) begin
                  state <= ST_FINISH;
                  done  <= 1'b1;
               end else if (!fifo.full) begin
                  word_bits <= '0;
                  if (bits_left == '0) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_SAMPLE;
                  end
               end
            end

            ST_FINISH: begin
               if (abort) begin
                  done <= 1'b1;
               end else begin
                  state     <= ST_IDLE;
                  use_lines <= '0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_rx_capture_ctrl.sv
// Directed self-checking bench for qspi_rx_capture_ctrl.
module tb_qspi_rx_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] rx_byte_count;
   logic [1:0]  lane_mode;
   logic        sample_pulse;
   logic        sample_en;
   logic        use_1, use_2, use_4;
   logic [31:0] sample_data;
   logic        sclk_hold, busy, done, err_mode, err_overrun;

   int n_vec = 0;
   int n_err = 0;
   int en_total = 0;
   int push_total = 0;
   int e0, p0, he;
   logic hl;

   qspi_rx_capture_ctrl_if fifo_if ();

   qspi_rx_capture_ctrl #(.CNT_W(16)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .abort              (abort),
      .rx_byte_count      (rx_byte_count),
      .lane_mode          (lane_mode),
      .sample_pulse       (sample_pulse),
      .sample_en          (sample_en),
      .use_1_io_lines_out (use_1),
      .use_2_io_lines_out (use_2),
      .use_4_io_lines_out (use_4),
      .sample_data        (sample_data),
      .fifo               (fifo_if.master),
      .sclk_hold          (sclk_hold),
      .busy               (busy),
      .done               (done),
      .err_mode           (err_mode),
      .err_overrun        (err_overrun)
   );

   always #5 clk = ~clk;

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (sample_en)    en_total++;
      if (fifo_if.push) push_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] cnt, input logic [1:0] mode);
      rx_byte_count = cnt;
      lane_mode     = mode;
      start         = 1'b1;
      step();
      start         = 1'b0;
   endtask

   // n back-to-back pulses; reports sclk_hold on the last pulse and early holds.
   task automatic pulses(input int n, output logic hold_last, output int hold_early);
      hold_last  = 1'b0;
      hold_early = 0;
      for (int i = 0; i < n; i++) begin
         sample_pulse = 1'b1;
         #1;
         if (i == n - 1) hold_last = sclk_hold;
         else if (sclk_hold) hold_early++;
         @(posedge clk);
         #1;
      end
      sample_pulse = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      rx_byte_count = '0;
      lane_mode     = 2'b00;
      sample_pulse  = 1'b0;
      sample_data   = '0;
      fifo_if.full  = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_hold",  32'(sclk_hold), 32'd0);
      check("rst_push",  32'(fifo_if.push), 32'd0);
      check("rst_use4",  32'(use_4), 32'd0);
      check("rst_errs",  32'({err_mode, err_overrun}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Quad, 8 bytes, FIFO free
      e0 = en_total; p0 = push_total;
      do_start(16'd8, 2'b10);
      check("q8_busy", 32'(busy), 32'd1);
      check("q8_use4", 32'({use_4, use_2, use_1}), 32'b100);
      pulses(8, hl, he);
      check("q8_hold_mealy", 32'(hl), 32'd1);
      check("q8_hold_early", 32'(he), 32'd0);
      sample_data = 32'h11223344;
      #1;
      check("q8_w0_push",   32'(fifo_if.push), 32'd1);
      check("q8_w0_nbytes", 32'(fifo_if.nbytes), 32'd4);
      check("q8_w0_last",   32'(fifo_if.last), 32'd0);
      check("q8_w0_data",   fifo_if.wdata, 32'h11223344);
      check("q8_w0_hold",   32'(sclk_hold), 32'd1);
      step();
      pulses(8, hl, he);
      sample_data = 32'h55667788;
      #1;
      check("q8_w1_push",   32'(fifo_if.push), 32'd1);
      check("q8_w1_nbytes", 32'(fifo_if.nbytes), 32'd4);
      check("q8_w1_last",   32'(fifo_if.last), 32'd1);
      check("q8_w1_data",   fifo_if.wdata, 32'h55667788);
      step();
      check("q8_done", 32'(done), 32'd1);
      check("q8_fin_hold", 32'(sclk_hold), 32'd1);
      step();
      check("q8_done_clr", 32'(done), 32'd0);
      check("q8_idle", 32'(busy), 32'd0);
      check("q8_en_cnt", 32'(en_total - e0), 32'd16);
      check("q8_push_cnt", 32'(push_total - p0), 32'd2);

      // Single line, 3 bytes -> one partial word
      e0 = en_total; p0 = push_total;
      do_start(16'd3, 2'b00);
      check("s3_use1", 32'({use_4, use_2, use_1}), 32'b001);
      pulses(24, hl, he);
      sample_data = 32'h00ABCDEF;
      #1;
      check("s3_push",   32'(fifo_if.push), 32'd1);
      check("s3_nbytes", 32'(fifo_if.nbytes), 32'd3);
      check("s3_last",   32'(fifo_if.last), 32'd1);
      check("s3_data",   fifo_if.wdata, 32'h00ABCDEF);
      step();
      check("s3_done", 32'(done), 32'd1);
      step();
      check("s3_en_cnt", 32'(en_total - e0), 32'd24);
      check("s3_push_cnt", 32'(push_total - p0), 32'd1);

      // Dual, 4 bytes, FIFO full for 5 cycles at word end, stray pulse in hold
      e0 = en_total; p0 = push_total;
      fifo_if.full = 1'b1;
      do_start(16'd4, 2'b01);
      pulses(16, hl, he);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) sample_pulse = 1'b1;
         #1;
         check("d4_hold_push", 32'(fifo_if.push), 32'd0);
         check("d4_hold_sclk", 32'(sclk_hold), 32'd1);
         if (k == 2) check("d4_stray_en", 32'(sample_en), 32'd0);
         step();
         sample_pulse = 1'b0;
      end
      fifo_if.full = 1'b0;
      sample_data  = 32'hCAFEF00D;
      #1;
      check("d4_push",   32'(fifo_if.push), 32'd1);
      check("d4_nbytes", 32'(fifo_if.nbytes), 32'd4);
      check("d4_last",   32'(fifo_if.last), 32'd1);
      check("d4_overrun", 32'(err_overrun), 32'd1);
      step();
      check("d4_done", 32'(done), 32'd1);
      step();
      check("d4_overrun_sticky", 32'(err_overrun), 32'd1);
      check("d4_en_cnt", 32'(en_total - e0), 32'd16);
      check("d4_push_cnt", 32'(push_total - p0), 32'd1);

      // count=0: immediate finish, clears previous errors
      e0 = en_total; p0 = push_total;
      do_start(16'd0, 2'b10);
      check("c0_done", 32'(done), 32'd1);
      check("c0_errs", 32'({err_mode, err_overrun}), 32'd0);
      step();
      check("c0_idle", 32'(busy), 32'd0);

      // Illegal lane mode
      do_start(16'd5, 2'b11);
      check("m3_done", 32'(done), 32'd1);
      check("m3_err_mode", 32'(err_mode), 32'd1);
      check("m3_use", 32'({use_4, use_2, use_1}), 32'd0);
      step();
      check("m3_err_sticky", 32'(err_mode), 32'd1);
      check("m3_idle", 32'(busy), 32'd0);
      check("c0m3_en_cnt", 32'(en_total - e0), 32'd0);
      check("c0m3_push_cnt", 32'(push_total - p0), 32'd0);

      // Quad, 16 bytes, abort after 10 pulses
      p0 = push_total;
      do_start(16'd16, 2'b10);
      check("ab_err_clr", 32'(err_mode), 32'd0);
      pulses(8, hl, he);
      step();
      pulses(2, hl, he);
      abort = 1'b1;
      #1;
      check("ab_push", 32'(fifo_if.push), 32'd0);
      step();
      abort = 1'b0;
      check("ab_done", 32'(done), 32'd1);
      step();
      check("ab_idle", 32'(busy), 32'd0);
      check("ab_push_cnt", 32'(push_total - p0), 32'd1);

      // Abort in PUSH beats a push to a free FIFO
      p0 = push_total;
      do_start(16'd4, 2'b10);
      pulses(8, hl, he);
      abort = 1'b1;
      #1;
      check("abp_push", 32'(fifo_if.push), 32'd0);
      step();
      abort = 1'b0;
      check("abp_done", 32'(done), 32'd1);
      step();
      check("abp_push_cnt", 32'(push_total - p0), 32'd0);

      // start with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("sa_busy", 32'(busy), 32'd0);
      check("sa_done", 32'(done), 32'd0);

      // Normal transfer after abort
      do_start(16'd4, 2'b10);
      pulses(8, hl, he);
      #1;
      check("re_push", 32'(fifo_if.push), 32'd1);
      check("re_last", 32'(fifo_if.last), 32'd1);
      step();
      check("re_done", 32'(done), 32'd1);
      step();

      // Async reset while stalled in PUSH
      fifo_if.full = 1'b1;
      do_start(16'd4, 2'b10);
      pulses(8, hl, he);
      step();
      check("rp_hold_pre", 32'(sclk_hold), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rp_busy", 32'(busy), 32'd0);
      check("rp_hold", 32'(sclk_hold), 32'd0);
      check("rp_done", 32'(done), 32'd0);
      check("rp_use4", 32'(use_4), 32'd0);
      #10;
      fifo_if.full = 1'b0;
      rst_n = 1'b1;
      step();
      p0 = push_total;
      do_start(16'd4, 2'b10);
      pulses(8, hl, he);
      #1;
      check("rp2_push",   32'(fifo_if.push), 32'd1);
      check("rp2_nbytes", 32'(fifo_if.nbytes), 32'd4);
      check("rp2_last",   32'(fifo_if.last), 32'd1);
      step();
      check("rp2_done", 32'(done), 32'd1);
      step();
      check("rp2_push_cnt", 32'(push_total - p0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
